// File: rtl/io_terminal_interface.sv
// Terminal I/O flags for the basic computer: keyboard bytes queue into INPR/FGI,
// OUT bytes are held in OUTR and handed to the printer, with FGO reporting when OUTR is free.
module io_terminal_interface #(
   parameter int KBD_DEPTH = 4,
   parameter int PRN_GAP   = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_kbd_data,
   input  logic       i_kbd_valid,
   output logic       o_kbd_ready,
   input  logic       i_inp_ack,
   output logic [7:0] o_inpr,
   output logic       o_fgi,
   input  logic       i_out_ld,
   input  logic [7:0] i_ac_low,
   output logic       o_fgo,
   output logic [7:0] o_prn_data,
   output logic       o_prn_valid,
   input  logic       i_prn_ready,
   input  logic       i_ien,
   output logic       o_irq,
   output logic [7:0] o_drop_cnt
);
   localparam int PW = $clog2(KBD_DEPTH);
   localparam int CW = $clog2(KBD_DEPTH + 1);
   localparam int GW = (PRN_GAP > 0) ? $clog2(PRN_GAP + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   logic [7:0]    r_mem [KBD_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_fgi;
   logic          w_kbd_ready;
   logic          w_push;
   logic          w_pop;

   state_t        r_state;
   state_t        w_state_next;
   logic [7:0]    r_outr;
   logic [GW-1:0] r_gap_cnt;
   logic          w_fgo;
   logic          w_prn_valid;

   logic [7:0]    r_drop_cnt;
   logic [1:0]    w_drop_inc;
   logic [8:0]    w_drop_sum;

   // Keyboard FIFO; pointers wrap naturally because depth is a power of two
   assign w_fgi       = (r_count != '0);
   assign w_kbd_ready = (r_count != CW'(KBD_DEPTH));
   assign w_push      = i_kbd_valid & w_kbd_ready;
   assign w_pop       = i_inp_ack & w_fgi;

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_kbd_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Printer FSM: state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_outr    <= 8'h00;
         r_gap_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_IDLE && i_out_ld)
            r_outr <= i_ac_low;
         if (r_state == S_SEND && i_prn_ready)
            r_gap_cnt <= GW'(PRN_GAP);
         else if (r_state == S_GAP)
            r_gap_cnt <= r_gap_cnt - GW'(1);
      end
   end

   // Printer FSM: next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_out_ld) w_state_next = S_SEND;
         S_SEND:  if (i_prn_ready) w_state_next = (PRN_GAP == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (r_gap_cnt == GW'(1)) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Printer FSM: outputs
   always_comb begin
      w_fgo       = 1'b0;
      w_prn_valid = 1'b0;
      case (r_state)
         S_IDLE:  w_fgo = 1'b1;
         S_SEND:  w_prn_valid = 1'b1;
         default: ;
      endcase
   end

   // Both an ignored INP and an ignored OUT in one cycle count twice
   assign w_drop_inc = {1'b0, i_inp_ack & ~w_fgi} + {1'b0, i_out_ld & ~w_fgo};
   assign w_drop_sum = {1'b0, r_drop_cnt} + {7'b0, w_drop_inc};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_drop_cnt <= 8'h00;
      else
         r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
   end

   assign o_kbd_ready = w_kbd_ready;
   assign o_fgi       = w_fgi;
   assign o_inpr      = w_fgi ? r_mem[r_rd_ptr] : 8'h00;
   assign o_fgo       = w_fgo;
   assign o_prn_data  = r_outr;
   assign o_prn_valid = w_prn_valid;
   assign o_irq       = i_ien & (w_fgi | w_fgo);
   assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_io_terminal_interface.sv
// Directed bench for io_terminal_interface with KBD_DEPTH=4, PRN_GAP=3.
module tb_io_terminal_interface;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] kbd_data;
   logic       kbd_valid;
   logic       kbd_ready;
   logic       inp_ack;
   logic [7:0] inpr;
   logic       fgi;
   logic       out_ld;
   logic [7:0] ac_low;
   logic       fgo;
   logic [7:0] prn_data;
   logic       prn_valid;
   logic       prn_ready;
   logic       ien;
   logic       irq;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   io_terminal_interface #(.KBD_DEPTH(4), .PRN_GAP(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_kbd_data(kbd_data), .i_kbd_valid(kbd_valid), .o_kbd_ready(kbd_ready),
      .i_inp_ack(inp_ack), .o_inpr(inpr), .o_fgi(fgi),
      .i_out_ld(out_ld), .i_ac_low(ac_low), .o_fgo(fgo),
      .o_prn_data(prn_data), .o_prn_valid(prn_valid), .i_prn_ready(prn_ready),
      .i_ien(ien), .o_irq(irq), .o_drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; kbd_data = 8'h00; kbd_valid = 1'b0; inp_ack = 1'b0;
      out_ld = 1'b0; ac_low = 8'h00; prn_ready = 1'b0; ien = 1'b0;
      #3;
      n_cmp++; if ({kbd_ready, fgi, fgo, prn_valid} !== 4'b1010) begin n_bad++;
         $display("FAIL reset_flags got=%b want=1010", {kbd_ready, fgi, fgo, prn_valid}); end
      n_cmp++; if ({inpr, prn_data, drop_cnt} !== 24'h0) begin n_bad++;
         $display("FAIL reset_data got=%h want=000000", {inpr, prn_data, drop_cnt}); end
      tick();
      rst_n = 1'b1;
      tick();
      $display("reset: flags=%b", {kbd_ready, fgi, fgo, prn_valid});
   endtask

   task automatic test_single();
      kbd_data = 8'h41; kbd_valid = 1'b1;
      tick();
      kbd_valid = 1'b0;
      n_cmp++; if ({fgi, inpr} !== {1'b1, 8'h41}) begin n_bad++;
         $display("FAIL single_push got fgi=%b inpr=%h want fgi=1 inpr=41", fgi, inpr); end
      inp_ack = 1'b1;
      tick();
      inp_ack = 1'b0;
      n_cmp++; if ({fgi, inpr} !== {1'b0, 8'h00}) begin n_bad++;
         $display("FAIL single_pop got fgi=%b inpr=%h want fgi=0 inpr=00", fgi, inpr); end
      $display("single: push 41 then INP");
   endtask

   task automatic test_full();
      for (int i = 1; i <= 4; i++) begin
         kbd_data = 8'(i); kbd_valid = 1'b1;
         tick();
      end
      n_cmp++; if ({kbd_ready, inpr} !== {1'b0, 8'h01}) begin n_bad++;
         $display("FAIL full_ready got ready=%b inpr=%h want ready=0 inpr=01", kbd_ready, inpr); end
      kbd_data = 8'h05;
      tick();
      n_cmp++; if ({kbd_ready, inpr} !== {1'b0, 8'h01}) begin n_bad++;
         $display("FAIL full_hold got ready=%b inpr=%h want ready=0 inpr=01", kbd_ready, inpr); end
      inp_ack = 1'b1;
      tick();
      inp_ack = 1'b0;
      n_cmp++; if ({kbd_ready, inpr} !== {1'b1, 8'h02}) begin n_bad++;
         $display("FAIL full_pop got ready=%b inpr=%h want ready=1 inpr=02", kbd_ready, inpr); end
      tick();
      kbd_valid = 1'b0;
      n_cmp++; if (kbd_ready !== 1'b0) begin n_bad++;
         $display("FAIL full_refill got ready=%b want 0", kbd_ready); end
      for (int i = 2; i <= 5; i++) begin
         n_cmp++; if ({fgi, inpr} !== {1'b1, 8'(i)}) begin n_bad++;
            $display("FAIL drain_%0d got fgi=%b inpr=%h want fgi=1 inpr=%h", i, fgi, inpr, 8'(i)); end
         inp_ack = 1'b1;
         tick();
         inp_ack = 1'b0;
      end
      n_cmp++; if ({fgi, kbd_ready, drop_cnt} !== {2'b01, 8'h00}) begin n_bad++;
         $display("FAIL drain_empty got fgi=%b ready=%b drop=%h want 0 1 00", fgi, kbd_ready, drop_cnt); end
      $display("full: 01..05 through depth-4 FIFO");
   endtask

   task automatic test_simul();
      kbd_data = 8'h11; kbd_valid = 1'b1;
      tick();
      kbd_data = 8'hAA; inp_ack = 1'b1;
      tick();
      kbd_valid = 1'b0; inp_ack = 1'b0;
      n_cmp++; if ({fgi, inpr} !== {1'b1, 8'hAA}) begin n_bad++;
         $display("FAIL simul_push_pop got fgi=%b inpr=%h want fgi=1 inpr=AA", fgi, inpr); end
      inp_ack = 1'b1;
      tick();
      inp_ack = 1'b0;
      n_cmp++; if (fgi !== 1'b0) begin n_bad++;
         $display("FAIL simul_empty got fgi=%b want 0", fgi); end
      $display("simul: push AA with INP at count 1");
   endtask

   task automatic test_printer();
      prn_ready = 1'b1; ac_low = 8'h5A; out_ld = 1'b1;
      tick();
      out_ld = 1'b0;
      n_cmp++; if ({prn_valid, fgo, prn_data} !== {2'b10, 8'h5A}) begin n_bad++;
         $display("FAIL prn_send got valid=%b fgo=%b data=%h want 1 0 5A", prn_valid, fgo, prn_data); end
      for (int k = 2; k <= 4; k++) begin
         tick();
         n_cmp++; if ({prn_valid, fgo} !== 2'b00) begin n_bad++;
            $display("FAIL prn_gap_c%0d got valid=%b fgo=%b want 0 0", k, prn_valid, fgo); end
      end
      tick();
      n_cmp++; if (fgo !== 1'b1) begin n_bad++;
         $display("FAIL prn_fgo_c5 got fgo=%b want 1", fgo); end
      $display("printer: 5A sent, FGO back after 5 cycles");
   endtask

   task automatic test_drop();
      prn_ready = 1'b0; ac_low = 8'h5A; out_ld = 1'b1;
      tick();
      ac_low = 8'hC3;
      tick();
      out_ld = 1'b0;
      n_cmp++; if ({prn_valid, prn_data, drop_cnt} !== {1'b1, 8'h5A, 8'h01}) begin n_bad++;
         $display("FAIL drop_out got valid=%b data=%h drop=%h want 1 5A 01", prn_valid, prn_data, drop_cnt); end
      inp_ack = 1'b1;
      tick();
      inp_ack = 1'b0;
      n_cmp++; if (drop_cnt !== 8'h02) begin n_bad++;
         $display("FAIL drop_inp got drop=%h want 02", drop_cnt); end
      inp_ack = 1'b1; out_ld = 1'b1;
      tick();
      inp_ack = 1'b0; out_ld = 1'b0;
      n_cmp++; if (drop_cnt !== 8'h04) begin n_bad++;
         $display("FAIL drop_both got drop=%h want 04", drop_cnt); end
      prn_ready = 1'b1;
      repeat (4) tick();
      n_cmp++; if ({fgo, prn_data} !== {1'b1, 8'h5A}) begin n_bad++;
         $display("FAIL drop_finish got fgo=%b data=%h want 1 5A", fgo, prn_data); end
      $display("drop: ignored OUT/INP counted, drop=%h", drop_cnt);
   endtask

   task automatic test_saturate();
      inp_ack = 1'b1;
      repeat (260) tick();
      inp_ack = 1'b0;
      n_cmp++; if (drop_cnt !== 8'hFF) begin n_bad++;
         $display("FAIL drop_sat got drop=%h want FF", drop_cnt); end
      $display("saturate: drop=%h", drop_cnt);
   endtask

   task automatic test_irq();
      ien = 1'b1; prn_ready = 1'b0;
      #1;
      n_cmp++; if (irq !== 1'b1) begin n_bad++;
         $display("FAIL irq_fgo got irq=%b want 1", irq); end
      ac_low = 8'h77; out_ld = 1'b1;
      tick();
      out_ld = 1'b0;
      n_cmp++; if ({irq, prn_valid} !== 2'b01) begin n_bad++;
         $display("FAIL irq_clear got irq=%b valid=%b want 0 1", irq, prn_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if ({prn_valid, fgo, irq, drop_cnt, prn_data} !== {3'b011, 16'h0000}) begin n_bad++;
         $display("FAIL irq_async_rst got valid=%b fgo=%b irq=%b drop=%h data=%h want 0 1 1 00 00",
                  prn_valid, fgo, irq, drop_cnt, prn_data); end
      tick();
      rst_n = 1'b1;
      tick();
      ien = 1'b0;
      #1;
      n_cmp++; if (irq !== 1'b0) begin n_bad++;
         $display("FAIL irq_ien_off got irq=%b want 0", irq); end
      $display("irq: raise, clear via OUT, async reset mid-SEND");
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_simul();
      test_printer();
      test_drop();
      test_saturate();
      test_irq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
